// File: rtl/keypad_pkg.sv
// Shared types for the keypad digit-entry block: decoded key codes,
// the blank-digit marker and the press-handling FSM states.
package keypad_pkg;

  typedef enum logic [3:0] {
    KEY_D0    = 4'd0,
    KEY_D1    = 4'd1,
    KEY_D2    = 4'd2,
    KEY_D3    = 4'd3,
    KEY_D4    = 4'd4,
    KEY_D5    = 4'd5,
    KEY_D6    = 4'd6,
    KEY_D7    = 4'd7,
    KEY_D8    = 4'd8,
    KEY_D9    = 4'd9,
    KEY_ENTER = 4'd10,
    KEY_BS    = 4'd11,
    KEY_CLR   = 4'd12,
    KEY_NONE  = 4'd15
  } key_t;

  localparam logic [3:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

endpackage

// File: rtl/keypad_decode.sv
// Combinational key decoder: maps a single set bit of the scanner vector
// to a key code. Zero bits, multiple bits or an unused position give KEY_NONE.
module keypad_decode
  import keypad_pkg::*;
(
  input  logic [15:0] i_onehot,
  output key_t        o_key
);

  // Exact-match lookup; every non-listed pattern falls to KEY_NONE.
  always_comb begin
    o_key = KEY_NONE;
    case (i_onehot)
      16'h0008: o_key = KEY_D0;
      16'h0080: o_key = KEY_D1;
      16'h0040: o_key = KEY_D2;
      16'h0020: o_key = KEY_D3;
      16'h0800: o_key = KEY_D4;
      16'h0400: o_key = KEY_D5;
      16'h0200: o_key = KEY_D6;
      16'h8000: o_key = KEY_D7;
      16'h4000: o_key = KEY_D8;
      16'h2000: o_key = KEY_D9;
      16'h0001: o_key = KEY_ENTER;
      16'h0010: o_key = KEY_BS;
      16'h0100: o_key = KEY_CLR;
      default:  o_key = KEY_NONE;
    endcase
  end

endmodule

// File: rtl/keypad_digit_entry.sv
// Keypad digit-entry buffer: decodes scanner keys, optionally debounces,
// performs exactly one action per press and holds a calculator-style BCD
// entry register (nibble 0 = most recent digit, BLANK = empty position).
// Optional feature macro: KEYPAD_DEBOUNCE_EN (adds DEBOUNCE state and 8-bit counter).
//
// state    | meaning
// IDLE     | no key held; waiting for a valid key
// DEBOUNCE | candidate key captured; counting identical samples
// HELD     | action done (or reset); waiting for release
module keypad_digit_entry
  import keypad_pkg::*;
#(
  parameter int DIGITS        = 3,
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W        = $clog2(DIGITS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [15:0]           i_onehot,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_full,
  output logic [4*DIGITS-1:0]   o_entered,
  output logic                  o_entered_valid,
  output logic                  o_key_strobe,
  output logic                  o_err
);

  localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};
  localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(DIGITS);

  key_t                w_key;
  logic                w_fire;
  state_t              r_state;
  logic [4*DIGITS-1:0] r_digits;
  logic [4*DIGITS-1:0] r_entered;
  logic [CNT_W-1:0]    r_count;
  logic                r_entered_valid;
  logic                r_key_strobe;
  logic                r_err;
`ifdef KEYPAD_DEBOUNCE_EN
  key_t                r_cand;
  logic [7:0]          r_cnt;
`endif

  keypad_decode u_decode (
    .i_onehot (i_onehot),
    .o_key    (w_key)
  );

  // Decide whether this edge completes a press and should perform its action.
  always_comb begin
    w_fire = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
    w_fire = (r_state == DEBOUNCE) && (w_key == r_cand) && (r_cnt == 8'(STABLE_CYCLES));
`else
    w_fire = (r_state == IDLE) && (w_key != KEY_NONE);
`endif
  end

  // Press FSM plus entry register and registered one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= HELD;
      r_digits        <= ALL_BLANK;
      r_entered       <= ALL_BLANK;
      r_count         <= '0;
      r_entered_valid <= 1'b0;
      r_key_strobe    <= 1'b0;
      r_err           <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
      r_cand          <= KEY_NONE;
      r_cnt           <= 8'd0;
`endif
    end else begin
      r_entered_valid <= 1'b0;
      r_key_strobe    <= 1'b0;
      r_err           <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_key != KEY_NONE) begin
`ifdef KEYPAD_DEBOUNCE_EN
            r_cand  <= w_key;
            r_cnt   <= 8'd1;
            r_state <= DEBOUNCE;
`else
            r_state <= HELD;
`endif
          end
        end
`ifdef KEYPAD_DEBOUNCE_EN
        DEBOUNCE: begin
          if (w_key != r_cand) begin
            r_state <= IDLE;
          end else if (r_cnt == 8'(STABLE_CYCLES)) begin
            r_state <= HELD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`endif
        HELD: begin
          if (w_key == KEY_NONE) r_state <= IDLE;
        end
        default: r_state <= HELD;
      endcase

      if (w_fire) begin
        if (w_key <= KEY_D9) begin
          if (r_count < CNT_MAX) begin
            r_digits     <= {r_digits[4*DIGITS-5:0], 4'(w_key)};
            r_count      <= r_count + 1'b1;
            r_key_strobe <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_key == KEY_BS) begin
          if (r_count != '0) begin
            r_digits     <= {BLANK, r_digits[4*DIGITS-1:4]};
            r_count      <= r_count - 1'b1;
            r_key_strobe <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_key == KEY_CLR) begin
          r_digits     <= ALL_BLANK;
          r_count      <= '0;
          r_key_strobe <= 1'b1;
        end else if (w_key == KEY_ENTER) begin
          if (r_count != '0) begin
            r_entered       <= r_digits;
            r_entered_valid <= 1'b1;
            r_digits        <= ALL_BLANK;
            r_count         <= '0;
            r_key_strobe    <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign o_digits        = r_digits;
  assign o_count         = r_count;
  assign o_full          = (r_count == CNT_MAX);
  assign o_entered       = r_entered;
  assign o_entered_valid = r_entered_valid;
  assign o_key_strobe    = r_key_strobe;
  assign o_err           = r_err;

endmodule

// File: doc/keypad_digit_entry.md
# keypad_digit_entry

- Parametrised keypad digit-entry buffer between the 4×4 keypad scanner (16-bit one-hot key vector) and the 7-segment display / downstream consumers.
- Decodes keys to digits and commands, optionally debounces, and performs one action per press.
- Holds a DIGITS-deep calculator-style BCD entry register with backspace, clear and enter.
- On enter, publishes the completed value with a one-cycle strobe.

## Interface
- DIGITS, 3 — entry depth in BCD digits; legal range 2..8.
- STABLE_CYCLES, 4 — debounce length; legal range 1..255. Used only with debounce compiled in.

Ports:
- clk  in  1  — sole clock; all state updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- onehot  in  16  — raw key vector from the scanner.
- digits  out  4*DIGITS  — live entry register. Nibble 0 holds the most recent digit; 4'hF marks a blank position.
- count  out  $clog2(DIGITS+1)  — number of digits entered.
- full  out  1  — high when count == DIGITS.
- entered  out  4*DIGITS  — value latched on the last accepted enter.
- entered_valid  out  1  — one-cycle pulse when entered is updated.
- key_strobe  out  1  — one-cycle pulse when any action is accepted.
- err  out  1  — one-cycle pulse when a press is rejected.

## Operation
Key decode. Applies only when onehot has exactly one bit set; anything else is KEY_NONE.

| onehot | key |
|---|---|
| 16'h0008 | 0 |
| 16'h0080 | 1 |
| 16'h0040 | 2 |
| 16'h0020 | 3 |
| 16'h0800 | 4 |
| 16'h0400 | 5 |
| 16'h0200 | 6 |
| 16'h8000 | 7 |
| 16'h4000 | 8 |
| 16'h2000 | 9 |
| 16'h0001 | ENTER |
| 16'h0010 | BACKSPACE |
| 16'h0100 | CLEAR |
| bits 1, 2, 12 | KEY_NONE |

FSM states:
- IDLE
  - Any valid key: capture it as the candidate and go to DEBOUNCE with cnt=1.
  - No debounce compiled in: perform the action immediately and go to HELD.
- DEBOUNCE
  - Decoded key differs from the candidate (including KEY_NONE): go to IDLE with no action.
  - Key matches and cnt == STABLE_CYCLES: perform the action and go to HELD.
  - Key matches otherwise: cnt++.
- HELD
  - Decoded key == KEY_NONE: go to IDLE. Otherwise stay.
  - There is exactly one action per press and no auto-repeat.

Actions, each raising key_strobe for one cycle:
- Digit d, count < DIGITS: digits <= {digits[4*DIGITS-5:0], d}; count++.
- BACKSPACE, count > 0: digits <= {4'hF, digits[4*DIGITS-1:4]}; count--.
- CLEAR: all nibbles set to 4'hF; count=0. Accepted even when count is already 0.
- ENTER, count > 0: entered <= digits; entered_valid pulses; digits is set to all 4'hF and count=0 in the same cycle.

Rejections raise err for one cycle, with no key_strobe and no state change:
- Digit while full.
- BACKSPACE while count == 0.
- ENTER while count == 0.

## Timing
Reset (rst high at an edge) sets:
- digits = all 4'hF; entered = all 4'hF; count = 0
- full, entered_valid, key_strobe, err = 0
- FSM = HELD, so a key held through reset must be released before it is accepted.

Latency, with debounce:
- The key must be decoded identically on STABLE_CYCLES+1 consecutive edges.
- The result is visible after the (STABLE_CYCLES+1)th edge.

Latency, without debounce:
- The result is visible after the first edge the key is sampled.

Pulses and outputs:
- All pulses are registered and last exactly one cycle.
- full is derived combinationally from registered count.
- rst has priority over any in-flight action; reset mid-debounce discards the candidate.

## Configuration
- KEYPAD_DEBOUNCE_EN defined: the DEBOUNCE state and an 8-bit cnt are present; STABLE_CYCLES is honoured.
- KEYPAD_DEBOUNCE_EN undefined: no DEBOUNCE state or counter; IDLE acts on the first valid sample; STABLE_CYCLES is ignored.

## Structure
- Package keypad_pkg holds:
  - key_t enum: KEY_D0..KEY_D9 = 4'd0..4'd9, KEY_ENTER, KEY_BS, KEY_CLR, KEY_NONE (4-bit).
  - BLANK = 4'hF.
  - state_t enum: IDLE, DEBOUNCE, HELD.
- Sub-module keypad_decode: purely combinational, 16-bit one-hot in, key_t out, with the mapping above.

## Test plan
Configuration: DIGITS=3, STABLE_CYCLES=4, debounce enabled. Each press is held for 6 cycles and then released.
- Press 16'h0080, 16'h0040, 16'h0020 → digits=12'h123, count=3, full=1; three key_strobe pulses.
- From 12'h123, press 16'h0800 → err pulse; digits stays 12'h123.
- Press 16'h0010 → digits=12'hF12, count=2.
- Press 16'h0001 → entered=12'hF12, entered_valid for 1 cycle; digits=12'hFFF, count=0.
- Press 16'h0001 with count=0 → err pulse only.
- 16'h0080 for 3 cycles then 0 → no strobe, digits unchanged.
- 16'h0088 (two keys) held 10 cycles → no action.
- Assert rst while 16'h0040 is held → outputs go to reset values; no digit entered until release; a fresh press then yields digits=12'hFF2.
